// File: rtl/tone_bank_modulator.sv
// Multi-tone keyer: NCH run-time programmable square-wave generators, timed key gate, registered output.
// Optional tone-count (sum) output mode is compiled in with `define TONE_MOD_SUM_EN.
module tone_bank_modulator #(
  parameter int NCH  = 8,
  parameter int DIVW = 20,
  parameter int DURW = 16,
  parameter int OUTW = 8,
  localparam int AW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [NCH-1:0]  chan_en,
  input  logic            carrier_in,
  input  logic            mode,
  input  logic            hold,
  input  logic            start,
  input  logic [DURW-1:0] dur,
  output logic            busy,
  output logic [NCH-1:0]  tones,
  output logic [OUTW-1:0] data_out
);

  logic [DIVW-1:0] div_q [NCH];
  logic [DIVW-1:0] div_d [NCH];
  logic [DIVW-1:0] cnt_q [NCH];
  logic [DIVW-1:0] cnt_d [NCH];
  logic [NCH-1:0]  tone_q, tone_d;
  logic            busy_q, busy_d;
  logic [DURW-1:0] dcnt_q, dcnt_d;
  logic [OUTW-1:0] data_q, data_d;

  logic            wr_hit;
  logic [NCH-1:0]  mixed;
  logic            gate;
  logic [OUTW-1:0] keyed;

`ifdef TONE_MOD_SUM_EN
  function automatic logic [OUTW-1:0] popcount(input logic [NCH-1:0] v);
    logic [OUTW-1:0] c;
    c = '0;
    for (int i = 0; i < NCH; i++) begin
      c = c + OUTW'(v[i]);
    end
    return c;
  endfunction
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  // Addresses beyond the last channel exist when NCH is not a power of two; those writes are dropped.
  assign wr_hit = cfg_we && ({1'b0, cfg_addr} < (AW+1)'(NCH));

  // Tone generators: a write restarts the channel and outranks a same-cycle toggle.
  always_comb begin
    tone_d = tone_q;
    for (int i = 0; i < NCH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
      if (wr_hit && (cfg_addr == AW'(i))) begin
        div_d[i]  = cfg_div;
        cnt_d[i]  = '0;
        tone_d[i] = 1'b0;
      end else if (div_q[i] == '0) begin
        cnt_d[i]  = '0;
        tone_d[i] = 1'b0;
      end else if (cnt_q[i] == div_q[i] - DIVW'(1)) begin
        cnt_d[i]  = '0;
        tone_d[i] = ~tone_q[i];
      end else begin
        cnt_d[i]  = cnt_q[i] + DIVW'(1);
      end
    end
  end

  // Burst gate: busy stays high for exactly dur cycles; starts while busy are dropped.
  always_comb begin
    busy_d = busy_q;
    dcnt_d = dcnt_q;
    if (!busy_q) begin
      if (start && (dur != '0)) begin
        busy_d = 1'b1;
        dcnt_d = dur;
      end
    end else if (dcnt_q == DURW'(1)) begin
      busy_d = 1'b0;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q - DURW'(1);
    end
  end

  // Output stage: keying is active when no enabled tone is high.
  always_comb begin
    mixed = tone_q & chan_en;
    gate  = busy_q | hold;
    keyed = (gate && carrier_in && (mixed == '0)) ? '1 : '0;
`ifdef TONE_MOD_SUM_EN
    data_d = mode ? (gate ? popcount(mixed) : '0) : keyed;
`else
    data_d = keyed;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      tone_q <= '0;
      busy_q <= 1'b0;
      dcnt_q <= '0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      tone_q <= tone_d;
      busy_q <= busy_d;
      dcnt_q <= dcnt_d;
      data_q <= data_d;
    end
  end

  assign busy     = busy_q;
  assign tones    = tone_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_tone_bank_modulator.sv
// Self-checking bench for tone_bank_modulator: behavioural model compared every cycle plus directed literal checks.
module tb_tone_bank_modulator;
  localparam int NCH  = 6;
  localparam int DIVW = 20;
  localparam int DURW = 16;
  localparam int OUTW = 8;
  localparam int AW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [DIVW-1:0] cfg_div;
  logic [NCH-1:0]  chan_en;
  logic            carrier_in;
  logic            mode;
  logic            hold;
  logic            start;
  logic [DURW-1:0] dur;
  logic            busy;
  logic [NCH-1:0]  tones;
  logic [OUTW-1:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tone_bank_modulator #(
    .NCH (NCH),
    .DIVW(DIVW),
    .DURW(DURW),
    .OUTW(OUTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_div   (cfg_div),
    .chan_en   (chan_en),
    .carrier_in(carrier_in),
    .mode      (mode),
    .hold      (hold),
    .start     (start),
    .dur       (dur),
    .busy      (busy),
    .tones     (tones),
    .data_out  (data_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Model: tone phase from elapsed edges since the last write, busy from the burst end edge.
  longint          t_m = 0;
  int              m_div [NCH];
  longint          m_wr  [NCH];
  longint          b_end = 0;
  logic [NCH-1:0]  exp_tones = '0;
  logic            exp_busy  = 1'b0;
  logic [OUTW-1:0] exp_data  = '0;
  bit              chk_en    = 1'b0;

  task automatic model_step();
    logic [NCH-1:0] pt;
    logic [NCH-1:0] mx;
    logic           pb;
    logic           g;
    t_m++;
    pt = exp_tones;
    pb = exp_busy;
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = 0;
        m_wr[i]  = 0;
      end
      b_end     = 0;
      exp_tones = '0;
      exp_busy  = 1'b0;
      exp_data  = '0;
    end else begin
      mx = pt & chan_en;
      g  = pb | hold;
      exp_data = (g && carrier_in && (mx == '0)) ? 8'hFF : 8'h00;
`ifdef TONE_MOD_SUM_EN
      if (mode) exp_data = g ? OUTW'($countones(mx)) : 8'h00;
`endif
      if (cfg_we && (int'(cfg_addr) < NCH)) begin
        m_div[int'(cfg_addr)] = int'(cfg_div);
        m_wr[int'(cfg_addr)]  = t_m;
      end
      if (start && !pb && (dur != '0)) b_end = t_m + longint'(dur);
      exp_busy = (t_m < b_end);
      for (int i = 0; i < NCH; i++) begin
        if (m_div[i] == 0) exp_tones[i] = 1'b0;
        else exp_tones[i] = ((((t_m - m_wr[i]) / longint'(m_div[i])) % 2) == 1);
      end
    end
    chk_en = 1'b1;
  endtask

  task automatic compare_all();
    check("tones", 32'(tones), 32'(exp_tones));
    check("busy", 32'(busy), 32'(exp_busy));
    check("data_out", 32'(data_out), 32'(exp_data));
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) if (chk_en) compare_all();

  task automatic write_div(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_div  = DIVW'(d);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [OUTW-1:0] a;
    logic [OUTW-1:0] b;
    int cnt;
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_div = '0; chan_en = '0;
    carrier_in = 1'b0; mode = 1'b0; hold = 1'b0; start = 1'b0; dur = '0;
    repeat (3) @(negedge clk);
    check("rst_tones", 32'(tones), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    rst = 1'b1;

    // ch0 div=4: low for 4 edges after the write, then high for 4
    write_div(0, 4);
    pat = 8'b1111_0000;
    for (int j = 0; j < 8; j++) begin
      check("ch0_phase", 32'(tones[0]), 32'(pat[j]));
      check("ch_others", 32'(tones[NCH-1:1]), 32'd0);
      @(negedge clk);
    end

    hold = 1'b1; carrier_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tones", 32'(tones), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    rst = 1'b1; hold = 1'b0;

    write_div(0, 4);
    write_div(6, 3);
    write_div(7, 5);
    repeat (10) @(negedge clk);

    hold = 1'b1; carrier_in = 1'b1; chan_en = '0;
    @(negedge clk);
    check("keyed_ff", 32'(data_out), 32'hFF);
    chan_en = 6'b000001;
    repeat (16) @(negedge clk);

    hold = 1'b0;
    start = 1'b1; dur = 16'd5;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int j = 0; j < 12; j++) begin
      cnt += int'(busy);
      start = (j == 2);
      dur = 16'd3;
      @(negedge clk);
    end
    start = 1'b0;
    check("burst_len", 32'(cnt), 32'd5);
    start = 1'b1; dur = 16'd0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    repeat (4) begin
      cnt += int'(busy);
      @(negedge clk);
    end
    check("dur0_ignored", 32'(cnt), 32'd0);

    mode = 1'b1; hold = 1'b1; carrier_in = 1'b1; chan_en = 6'b000111;
    write_div(0, 1);
    @(negedge clk);
    write_div(1, 1);
    @(negedge clk);
    write_div(2, 1);
    repeat (3) @(negedge clk);
    a = data_out;
    @(negedge clk);
    b = data_out;
`ifdef TONE_MOD_SUM_EN
    check("sum_pair_total", 32'(a) + 32'(b), 32'd3);
`else
    check("sum_pair_total", 32'(a) + 32'(b), 32'd255);
`endif
    check("sum_pair_prod", 32'(a) * 32'(b), 32'd0);
    hold = 1'b0;
    @(negedge clk);
    check("gate_off", 32'(data_out), 32'd0);

    repeat (500) begin
      rst        = ($urandom_range(63) != 0);
      cfg_we     = ($urandom_range(7) == 0);
      cfg_addr   = AW'($urandom_range(7));
      cfg_div    = DIVW'($urandom_range(12));
      chan_en    = NCH'($urandom);
      carrier_in = ($urandom_range(3) != 0);
      mode       = $urandom_range(1) == 1;
      hold       = ($urandom_range(3) == 0);
      start      = ($urandom_range(3) == 0);
      dur        = DURW'($urandom_range(8));
      @(negedge clk);
    end
    rst = 1'b1; cfg_we = 1'b0; start = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
